// File: rtl/spi_ctrl_pkg.sv
// Shared types, default command codes and address-wrap helper for the SPI
// register-access sequencer.
package spi_ctrl_pkg;

    // Sequencer state; also exported on mode_o for status/debug.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_INFO = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_DATA = 3'd4
    } state_t;

    // Default command byte encodings.
    localparam logic [7:0] CMD_INFO_RD_DEF = 8'h3a;
    localparam logic [7:0] CMD_DATA_RD_DEF = 8'h3b;
    localparam logic [7:0] CMD_REG_WR_DEF  = 8'h3c;

    // Next address inside the region [lo, hi]; hi wraps back to lo.
    // Operates on 8-bit values so it covers every legal address width.
    function automatic logic [7:0] region_next(
        input logic [7:0] addr,
        input logic [7:0] lo,
        input logic [7:0] hi
    );
        return (addr == hi) ? lo : addr + 8'd1;
    endfunction

endpackage

// File: rtl/reg_addr_gen.sv
// Loadable address counter that steps within a region [lo_i, hi_i] and
// wraps from hi_i back to lo_i. Used for the read-prefetch address.
module reg_addr_gen
    import spi_ctrl_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              step_i,
    input  logic [ADDR_W-1:0] lo_i,
    input  logic [ADDR_W-1:0] hi_i,
    output logic [ADDR_W-1:0] addr_o
);

    logic [7:0] next8;

    // Compute the wrapped successor of the current address.
    always_comb begin
        next8 = region_next(8'(addr_o), 8'(lo_i), 8'(hi_i));
    end

    // Counter register: load has priority over step; holds otherwise.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            addr_o <= '0;
        end else if (load_i) begin
            addr_o <= load_val_i;
        end else if (step_i) begin
            addr_o <= ADDR_W'(next8);
        end
    end

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI command/data decoder: turns accepted command and data bytes into
// one-cycle read-prefetch and write strobes toward the register file.
module spi_reg_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int         ADDR_W      = 4,
    parameter int         DATA_BASE   = 8,
    parameter logic [7:0] CMD_INFO_RD = CMD_INFO_RD_DEF,
    parameter logic [7:0] CMD_DATA_RD = CMD_DATA_RD_DEF,
    parameter logic [7:0] CMD_REG_WR  = CMD_REG_WR_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              dc_i,
    input  logic              spi_byte_vld_i,
    input  logic [7:0]        spi_byte_data_i,
    output logic              reg_rd_en_o,
    output logic [ADDR_W-1:0] reg_rd_addr_o,
    output logic              reg_wr_en_o,
    output logic [ADDR_W-1:0] reg_wr_addr_o,
    output logic [7:0]        reg_wr_data_o,
    output logic [2:0]        mode_o
);

    // Elaboration-time parameter legality checks.
    if (ADDR_W < 2 || ADDR_W > 8) begin : g_chk_addr_w
        $error("spi_reg_ctrl: ADDR_W=%0d outside legal range 2..8", ADDR_W);
    end
    if (DATA_BASE < 1 || DATA_BASE > (1 << ADDR_W) - 1) begin : g_chk_data_base
        $error("spi_reg_ctrl: DATA_BASE=%0d outside legal range 1..2**ADDR_W-1", DATA_BASE);
    end

    // Region bounds: INFO = [0, DATA_BASE-1], DATA = [DATA_BASE, 2**ADDR_W-1].
    localparam logic [ADDR_W-1:0] INFO_LO = '0;
    localparam logic [ADDR_W-1:0] INFO_HI = ADDR_W'(DATA_BASE - 1);
    localparam logic [ADDR_W-1:0] DATA_LO = ADDR_W'(DATA_BASE);
    localparam logic [ADDR_W-1:0] DATA_HI = '1;

    state_t            state;
    state_t            state_nxt;
    logic              cmd_acc;
    logic              dat_acc;
    logic              rd_load;
    logic [ADDR_W-1:0] rd_load_val;
    logic              rd_step;
    logic [ADDR_W-1:0] rd_lo;
    logic [ADDR_W-1:0] rd_hi;
    logic              rd_en_nxt;
    logic              wr_en_nxt;
    logic              wr_ptr_load;
    logic [ADDR_W-1:0] wr_ptr;

    assign cmd_acc = spi_byte_vld_i && !dc_i;
    assign dat_acc = spi_byte_vld_i &&  dc_i;
    assign mode_o  = state;

    // State register; reset wins over any byte accepted in the same cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and strobe decode for the current accepted byte.
    // NOTE: every signal gets a default first so no path infers a latch.
    always_comb begin
        state_nxt   = state;
        rd_load     = 1'b0;
        rd_load_val = INFO_LO;
        rd_step     = 1'b0;
        rd_en_nxt   = 1'b0;
        wr_en_nxt   = 1'b0;
        wr_ptr_load = 1'b0;
        rd_lo       = (state == RD_DATA) ? DATA_LO : INFO_LO;
        rd_hi       = (state == RD_DATA) ? DATA_HI : INFO_HI;

        if (cmd_acc) begin
            // Any command aborts the current transfer.
            if (spi_byte_data_i == CMD_INFO_RD) begin
                state_nxt   = RD_INFO;
                rd_load     = 1'b1;
                rd_load_val = INFO_LO;
                rd_en_nxt   = 1'b1;
            end else if (spi_byte_data_i == CMD_DATA_RD) begin
                state_nxt   = RD_DATA;
                rd_load     = 1'b1;
                rd_load_val = DATA_LO;
                rd_en_nxt   = 1'b1;
            end else if (spi_byte_data_i == CMD_REG_WR) begin
                state_nxt   = WR_ADDR;
            end else begin
                state_nxt   = IDLE;
            end
        end else if (dat_acc) begin
            case (state)
                RD_INFO, RD_DATA: begin
                    rd_step   = 1'b1;
                    rd_en_nxt = 1'b1;
                end
                WR_ADDR: begin
                    wr_ptr_load = 1'b1;
                    state_nxt   = WR_DATA;
                end
                WR_DATA: begin
                    wr_en_nxt = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Read address counter with region-bounded wrap.
    reg_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_rd_addr (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load_i     (rd_load),
        .load_val_i (rd_load_val),
        .step_i     (rd_step),
        .lo_i       (rd_lo),
        .hi_i       (rd_hi),
        .addr_o     (reg_rd_addr_o)
    );

    // Registered strobes, write address/data, and free-running write pointer.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            reg_rd_en_o   <= 1'b0;
            reg_wr_en_o   <= 1'b0;
            reg_wr_addr_o <= '0;
            reg_wr_data_o <= '0;
            wr_ptr        <= '0;
        end else begin
            reg_rd_en_o <= rd_en_nxt;
            reg_wr_en_o <= wr_en_nxt;
            if (wr_ptr_load) begin
                wr_ptr <= ADDR_W'(spi_byte_data_i);
            end else if (wr_en_nxt) begin
                reg_wr_addr_o <= wr_ptr;
                reg_wr_data_o <= spi_byte_data_i;
                wr_ptr        <= wr_ptr + ADDR_W'(1);
            end
        end
    end

endmodule
